// File: rtl/intp_ctrl_pkg.sv
// Shared definitions for the prioritised, maskable interrupt controller:
// FSM states, register offsets relative to the channel count, id width.
package intp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } intp_state_e;

    function automatic int unsigned en_ofs(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned mode_ofs(input int unsigned n);
        return n + 1;
    endfunction

    function automatic int unsigned pend_ofs(input int unsigned n);
        return n + 2;
    endfunction

    function automatic int unsigned stat_ofs(input int unsigned n);
        return n + 3;
    endfunction

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intp_prio_arbiter.sv
// Combinational priority select: highest PRIO among eligible channels wins,
// equal priorities resolve to the lowest channel index.
module intp_prio_arbiter
    import intp_ctrl_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned PRIO_WIDTH = 4
) (
    input  logic [N-1:0]              elig,
    input  logic [N*PRIO_WIDTH-1:0]   prio,
    output logic                      any_elig,
    output logic [id_width(N)-1:0]    winner_id
);

    logic [PRIO_WIDTH-1:0] best;

    // Strict greater-than keeps the earliest (lowest index) channel on ties.
    always_comb begin
        any_elig  = 1'b0;
        winner_id = '0;
        best      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i] && (!any_elig || prio[i*PRIO_WIDTH +: PRIO_WIDTH] > best)) begin
                any_elig  = 1'b1;
                best      = prio[i*PRIO_WIDTH +: PRIO_WIDTH];
                winner_id = id_width(N)'(i);
            end
        end
    end

endmodule

// File: rtl/intp_ctrl_prio_mask.sv
// APB-configured interrupt controller: per-channel priority, enable and
// level/edge mode, pending/status registers, one request/acknowledge pair.
module intp_ctrl_prio_mask
    import intp_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OF_PERIPHERALS = 16,
    parameter int unsigned PRIO_WIDTH         = 4,
    parameter int unsigned ADDR_WIDTH         = 5,
    parameter int unsigned DATA_WIDTH         = 32
) (
    input  logic                                  pclk_i,
    input  logic                                  prst_i,
    input  logic                                  psel_i,
    input  logic                                  penable_i,
    input  logic                                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0]                 paddr_i,
    input  logic [DATA_WIDTH-1:0]                 pwdata_i,
    output logic [DATA_WIDTH-1:0]                 prdata_o,
    output logic                                  pready_o,
    output logic                                  perror_o,
    input  logic [NUM_OF_PERIPHERALS-1:0]         intp_active_i,
    output logic                                  intp_valid_o,
    output logic [id_width(NUM_OF_PERIPHERALS)-1:0] intp_to_service_o,
    input  logic                                  intp_serviced_i
);

    localparam int unsigned N      = NUM_OF_PERIPHERALS;
    localparam int unsigned ID_W   = id_width(N);
    localparam int unsigned EN_A   = en_ofs(N);
    localparam int unsigned MODE_A = mode_ofs(N);
    localparam int unsigned PEND_A = pend_ofs(N);
    localparam int unsigned STAT_A = stat_ofs(N);

    logic [PRIO_WIDTH-1:0]   prio_q [N];
    logic [N*PRIO_WIDTH-1:0] prio_flat;
    logic [N-1:0]            en_q, mode_q, pend_q, act_q, pend_d;
    logic [N-1:0]            elig, rise, clr, w1c, mode_chg, svc_clr;
    logic                    acc_q, access, err, wr_ok, prio_bad;
    logic [31:0]             addr_w;
    logic [DATA_WIDTH-1:0]   rdata, status;

    intp_state_e             state_q, state_d;
    logic                    valid_q, valid_d, any_elig;
    logic [ID_W-1:0]         id_q, id_d, win_id;

    // Only the first cycle of an access phase counts; a held phase is ignored.
    assign access   = psel_i & penable_i & ~acc_q;
    assign addr_w   = 32'(paddr_i);
    assign prio_bad = (pwdata_i >> PRIO_WIDTH) != '0;
    assign err      = (addr_w > STAT_A)
                    | (pwrite_i & (addr_w == STAT_A))
                    | (pwrite_i & (addr_w < N) & prio_bad);
    assign wr_ok    = access & pwrite_i & ~err;

    always_comb begin
        prio_flat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] = prio_q[i];
        end
    end

    always_comb begin
        status           = '0;
        status[0]        = valid_q;
        status[8 +: ID_W] = id_q;
    end

    always_comb begin
        rdata = '0;
        if (addr_w < N)            rdata = DATA_WIDTH'(prio_q[paddr_i[ID_W-1:0]]);
        else if (addr_w == EN_A)   rdata = DATA_WIDTH'(en_q);
        else if (addr_w == MODE_A) rdata = DATA_WIDTH'(mode_q);
        else if (addr_w == PEND_A) rdata = DATA_WIDTH'(pend_q);
        else if (addr_w == STAT_A) rdata = status;
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            acc_q    <= 1'b0;
            pready_o <= 1'b0;
            perror_o <= 1'b0;
            prdata_o <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            for (int unsigned i = 0; i < N; i++) prio_q[i] <= '0;
        end else begin
            acc_q    <= psel_i & penable_i;
            pready_o <= access;
            perror_o <= access & err;
            if (access) prdata_o <= pwrite_i ? '0 : rdata;
            if (wr_ok && addr_w == EN_A)   en_q   <= pwdata_i[N-1:0];
            if (wr_ok && addr_w == MODE_A) mode_q <= pwdata_i[N-1:0];
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_ok && addr_w == i) prio_q[i] <= pwdata_i[PRIO_WIDTH-1:0];
            end
        end
    end

    // Edge bits: new rise beats any clear; a mode change resets the bit.
    always_comb begin
        rise     = intp_active_i & ~act_q;
        w1c      = (wr_ok && addr_w == PEND_A) ? (pwdata_i[N-1:0] & mode_q) : '0;
        mode_chg = (wr_ok && addr_w == MODE_A) ? (pwdata_i[N-1:0] ^ mode_q) : '0;
        clr      = w1c | svc_clr;
        pend_d   = ((mode_q & (rise | (pend_q & ~clr))) | (~mode_q & intp_active_i)) & ~mode_chg;
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            act_q  <= '0;
            pend_q <= '0;
        end else begin
            act_q  <= intp_active_i;
            pend_q <= pend_d;
        end
    end

    assign elig = pend_q & en_q;

    intp_prio_arbiter #(
        .N          (N),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_arb (
        .elig      (elig),
        .prio      (prio_flat),
        .any_elig  (any_elig),
        .winner_id (win_id)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        svc_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    id_d    = win_id;
                    valid_d = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (intp_serviced_i) begin
                    valid_d = 1'b0;
                    svc_clr = N'(1) << id_q;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign intp_valid_o      = valid_q;
    assign intp_to_service_o = id_q;

endmodule

// File: doc/intp_ctrl_prio_mask.md
Name: intp_ctrl_prio_mask

Overview:
- Parametrised successor to the APB interrupt controller.
- Arbitrates N peripheral interrupt lines using per-channel programmable priority.
- Adds per-channel enable mask, per-channel level/edge mode, a readable and clearable pending register, and a status register.
- Sits between peripheral interrupt sources and the processor's single interrupt/acknowledge pair. The processor configures it over APB.

Parameters:
- NUM_OF_PERIPHERALS, 16, number of interrupt lines (2..32).
- PRIO_WIDTH, 4, priority field width; larger value means higher priority.
- ADDR_WIDTH, 5, APB word-address width; must satisfy 2^ADDR_WIDTH >= NUM_OF_PERIPHERALS+4.
- DATA_WIDTH, 32, APB data width; must be >= NUM_OF_PERIPHERALS and >= PRIO_WIDTH.

Ports:
- pclk_i  in  1  single clock, rising edge.
- prst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_WIDTH  word address.
- pwdata_i  in  DATA_WIDTH  write data.
- prdata_o  out  DATA_WIDTH  read data, registered.
- pready_o  out  1  transfer complete.
- perror_o  out  1  slave error, valid with pready_o.
- intp_active_i  in  NUM_OF_PERIPHERALS  raw interrupt requests.
- intp_valid_o  out  1  interrupt presented to processor.
- intp_to_service_o  out  $clog2(NUM_OF_PERIPHERALS)  winning channel id.
- intp_serviced_i  in  1  processor acknowledge, one-cycle pulse or level.

Behaviour:
- Reset (prst_i=0, async):
  - Outputs: prdata_o=0, pready_o=0, perror_o=0, intp_valid_o=0, intp_to_service_o=0.
  - State: all PRIO=0, EN=0, MODE=0 (level), PEND=0, edge history=0, FSM=IDLE.
- Register map (word address):
  - 0..N-1: PRIO[i], RW, bits [PRIO_WIDTH-1:0].
  - N: EN, RW, bit i enables channel i.
  - N+1: MODE, RW, 1=edge, 0=level.
  - N+2: PEND, RO view of pending; write-1-to-clear edge bits only.
  - N+3: STATUS, RO, {id at [15:8], valid at [0]}.
  - Others: unmapped.
- APB timing:
  - Zero wait state: pready_o is registered and high in the cycle after psel_i&penable_i rise, for one cycle.
  - Write takes effect at the same edge that raises pready_o.
  - prdata_o is updated at that edge.
  - Each access must be a distinct setup/access pair; a held access phase is not repeated.
- perror_o=1 with pready_o on any of:
  - unmapped address;
  - write to N+3;
  - PRIO write with pwdata_i bits above PRIO_WIDTH non-zero (register unchanged).
  - Reads of unmapped addresses return 0.
- Pending:
  - Level channel: pend[i] = intp_active_i[i], registered one cycle.
  - Edge channel: pend[i] sets on a registered 0->1 transition and holds until cleared.
  - Edge bit is cleared by service of that channel or by a PEND W1C.
  - Set and clear in the same cycle: set wins.
  - Switching MODE clears that channel's edge pend bit.
- Eligibility: elig = pend & EN.
- Arbitration: highest PRIO among elig wins; ties go to the lowest index. Combinational over registered pend.
- FSM:
  - IDLE: if elig != 0, latch the winner into intp_to_service_o and set intp_valid_o=1 at the next edge, then go to ACTIVE. Latency is 1 cycle from elig to valid.
  - ACTIVE: hold id and valid. No preemption; a higher-priority arrival, masking, or source drop does not change the output. When intp_serviced_i=1, set intp_valid_o=0 at the next edge, clear the edge pend bit of the serviced id, and go to GAP.
  - GAP: one cycle with no arbitration so level sources can deassert, then go to IDLE.
  - intp_serviced_i outside ACTIVE is ignored.
- Service-to-next-valid latency: at least 3 cycles (ACTIVE->GAP->IDLE->ACTIVE).
- An async reset in ACTIVE drops intp_valid_o immediately; the pending interrupt is lost.

Decomposition:
- Package intp_ctrl_pkg:
  - FSM state enum {IDLE, ACTIVE, GAP};
  - register offset function/constants relative to NUM_OF_PERIPHERALS (EN_OFS, MODE_OFS, PEND_OFS, STAT_OFS);
  - id width helper.
- Sub-module intp_prio_arbiter (combinational):
  - inputs: elig vector, flattened PRIO array;
  - outputs: any_o, winner id.
  - Parametrised by N and PRIO_WIDTH; linear or tree compare with lowest-index tie-break.

Test Plan:
- Reset, then read all addresses -> all 0, perror_o=0. Read address 31 (N=16) -> prdata 0, perror_o=1.
- PRIO[3]=9, PRIO[7]=9, PRIO[12]=2; EN=0xFFFF; level; intp_active_i=0x1088 -> id 3 (tie to lowest index). After ack and drop of line 3 -> id 7, then id 12.
- EN=0x0004, intp_active_i=0xFFFF -> only id 2 is ever presented. Set EN=0 while ACTIVE -> valid stays until ack.
- MODE[5]=1, pulse intp_active_i[5] for one cycle -> PEND reads 0x0020 and valid rises with id 5. Ack -> PEND=0, no re-trigger.
- Edge pulse on ch 9 in the same cycle as a PEND W1C of bit 9 -> bit stays set (set wins).
- Write PRIO[0]=0x1F with PRIO_WIDTH=4 -> perror_o=1, PRIO[0] unchanged. Async reset mid-ACTIVE -> intp_valid_o=0 immediately.
